// File: rtl/c_tile_bank_ctrl.sv
// C-tile accumulation buffer: a ring of NUM_BANKS partial-sum banks, each holding one C tile.
// Each tile takes N_in passes. Every pass reads the tile's partial sums and writes them back.
// The load side reads partial sums; reads on the first pass return zero.
// The store side writes the updated sums back.
// After the final pass a bank is FULL and is drained in completion order over a valid/ready stream.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   N_in            passes per tile (0 behaves as 1), static while any bank is busy
//   load_en_in      read next element of the load bank; rd_data_out valid 2 cycles later
//   store_en_in     write wr_data_in to next element of the store bank
//   tile_ready_out  load bank is FREE or ACTIVE
//   out_valid/out_ready/out_data/out_last  drain stream, out_last on the last element
//   err_out         sticky protocol error (load into busy bank, store into non-ACTIVE bank)
module c_tile_bank_ctrl #(
   parameter int unsigned D_WIDTH     = 64,
   parameter int unsigned ADDR_WTH    = 2,
   parameter int unsigned NUM_BANKS   = 2,
   parameter int unsigned N_MAX_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_MAX_WIDTH-1:0] N_in,
   input  logic                   load_en_in,
   output logic [D_WIDTH-1:0]     rd_data_out,
   input  logic                   store_en_in,
   input  logic [D_WIDTH-1:0]     wr_data_in,
   output logic                   tile_ready_out,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [D_WIDTH-1:0]     out_data,
   output logic                   out_last,
   output logic                   err_out
);

   localparam int unsigned Depth = 2 ** ADDR_WTH;
   localparam int unsigned BankW = $clog2(NUM_BANKS);

   typedef enum logic [1:0] {BkFree, BkActive, BkFull, BkDraining} bank_st_e;
   typedef enum logic [1:0] {DrIdle, DrRd, DrHold} drain_st_e;

   logic [D_WIDTH-1:0] mem_q [NUM_BANKS*Depth];

   bank_st_e                bank_q [NUM_BANKS];
   bank_st_e                bank_d [NUM_BANKS];
   logic [BankW-1:0]        ld_ptr_q, ld_ptr_d, st_ptr_q, st_ptr_d, dr_ptr_q, dr_ptr_d;
   logic [ADDR_WTH-1:0]     ld_addr_q, ld_addr_d, st_addr_q, st_addr_d, dr_addr_q, dr_addr_d;
   logic [N_MAX_WIDTH-1:0]  ld_pass_q, ld_pass_d, st_pass_q, st_pass_d;
   drain_st_e               dr_st_q, dr_st_d;
   logic                    dr_done_q, dr_done_d;
   logic                    tile_ready_q, tile_ready_d;
   logic                    err_q, err_d;

   // Load read pipeline: stage 1 holds raw data plus the first-pass zero flag.
   logic                    ld_v1_q, ld_zero1_q;
   logic [D_WIDTH-1:0]      ld_data1_q, rd_data_q;

   // Drain read pipeline (one stage) feeding a 2-entry skid FIFO.
   logic                    dr_v1_q, dr_last1_q;
   logic [D_WIDTH-1:0]      dr_data1_q;
   logic [D_WIDTH-1:0]      fifo_data_q [2];
   logic                    fifo_last_q [2];
   logic                    fifo_wp_q, fifo_rp_q;
   logic [1:0]              fifo_cnt_q;

   logic [N_MAX_WIDTH-1:0]  n_last;
   logic                    ld_ok, ld_bad, st_ok, st_bad;
   logic                    pop, dr_issue, dr_fin;
   logic [2:0]              occ;

   // N_in of 0 means a single pass.
   assign n_last = (N_in == '0) ? '0 : N_in - N_MAX_WIDTH'(1);

   assign ld_ok  = load_en_in &&
                   (bank_q[ld_ptr_q] == BkFree || bank_q[ld_ptr_q] == BkActive);
   assign ld_bad = load_en_in && !ld_ok;
   assign st_ok  = store_en_in && (bank_q[st_ptr_q] == BkActive);
   assign st_bad = store_en_in && !st_ok;

   assign pop    = (fifo_cnt_q != 2'd0) && out_ready;
   assign dr_fin = pop && fifo_last_q[fifo_rp_q];
   // Occupancy after this cycle's pop, counting the read already in flight.
   assign occ      = {1'b0, fifo_cnt_q} - 3'(pop) + 3'(dr_v1_q);
   assign dr_issue = (dr_st_q == DrRd) && !dr_done_q && (occ < 3'd2);

   always_comb begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) bank_d[i] = bank_q[i];
      ld_ptr_d  = ld_ptr_q;
      ld_addr_d = ld_addr_q;
      ld_pass_d = ld_pass_q;
      st_ptr_d  = st_ptr_q;
      st_addr_d = st_addr_q;
      st_pass_d = st_pass_q;
      dr_st_d   = dr_st_q;
      dr_ptr_d  = dr_ptr_q;
      dr_addr_d = dr_addr_q;
      dr_done_d = dr_done_q;
      err_d     = err_q | ld_bad | st_bad;

      if (ld_ok) begin
         if (bank_q[ld_ptr_q] == BkFree) bank_d[ld_ptr_q] = BkActive;
         ld_addr_d = ld_addr_q + ADDR_WTH'(1);
         if (&ld_addr_q) begin
            if (ld_pass_q == n_last) begin
               ld_pass_d = '0;
               ld_ptr_d  = ld_ptr_q + BankW'(1);
            end else begin
               ld_pass_d = ld_pass_q + N_MAX_WIDTH'(1);
            end
         end
      end

      if (st_ok) begin
         st_addr_d = st_addr_q + ADDR_WTH'(1);
         if (&st_addr_q) begin
            if (st_pass_q == n_last) begin
               st_pass_d        = '0;
               st_ptr_d         = st_ptr_q + BankW'(1);
               bank_d[st_ptr_q] = BkFull;
            end else begin
               st_pass_d = st_pass_q + N_MAX_WIDTH'(1);
            end
         end
      end

      if (dr_issue) begin
         dr_addr_d = dr_addr_q + ADDR_WTH'(1);
         if (&dr_addr_q) dr_done_d = 1'b1;
      end

      case (dr_st_q)
         DrIdle: begin
            if (bank_q[dr_ptr_q] == BkFull) begin
               bank_d[dr_ptr_q] = BkDraining;
               dr_addr_d        = '0;
               dr_done_d        = 1'b0;
               dr_st_d          = DrRd;
            end
         end
         DrRd: begin
            if (fifo_cnt_q == 2'd2 && !pop) dr_st_d = DrHold;
         end
         DrHold: begin
            if (pop) dr_st_d = DrRd;
         end
         default: dr_st_d = DrIdle;
      endcase

      // Last beat leaving the FIFO releases the bank regardless of RD/HOLD.
      if (dr_st_q != DrIdle && dr_fin) begin
         bank_d[dr_ptr_q] = BkFree;
         dr_ptr_d         = dr_ptr_q + BankW'(1);
         dr_st_d          = DrIdle;
      end

      tile_ready_d = (bank_d[ld_ptr_d] == BkFree) || (bank_d[ld_ptr_d] == BkActive);
   end

   // Storage is not reset: first-pass zero forcing hides stale contents.
   always_ff @(posedge clk) begin
      if (st_ok) mem_q[{st_ptr_q, st_addr_q}] <= wr_data_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_BANKS; i++) bank_q[i] <= BkFree;
         ld_ptr_q     <= '0;
         ld_addr_q    <= '0;
         ld_pass_q    <= '0;
         st_ptr_q     <= '0;
         st_addr_q    <= '0;
         st_pass_q    <= '0;
         dr_st_q      <= DrIdle;
         dr_ptr_q     <= '0;
         dr_addr_q    <= '0;
         dr_done_q    <= 1'b0;
         tile_ready_q <= 1'b0;
         err_q        <= 1'b0;
         ld_v1_q      <= 1'b0;
         ld_zero1_q   <= 1'b0;
         ld_data1_q   <= '0;
         rd_data_q    <= '0;
         dr_v1_q      <= 1'b0;
         dr_last1_q   <= 1'b0;
         dr_data1_q   <= '0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
         fifo_wp_q    <= 1'b0;
         fifo_rp_q    <= 1'b0;
         fifo_cnt_q   <= 2'd0;
      end else begin
         for (int unsigned i = 0; i < NUM_BANKS; i++) bank_q[i] <= bank_d[i];
         ld_ptr_q     <= ld_ptr_d;
         ld_addr_q    <= ld_addr_d;
         ld_pass_q    <= ld_pass_d;
         st_ptr_q     <= st_ptr_d;
         st_addr_q    <= st_addr_d;
         st_pass_q    <= st_pass_d;
         dr_st_q      <= dr_st_d;
         dr_ptr_q     <= dr_ptr_d;
         dr_addr_q    <= dr_addr_d;
         dr_done_q    <= dr_done_d;
         tile_ready_q <= tile_ready_d;
         err_q        <= err_d;

         ld_v1_q <= ld_ok;
         if (ld_ok) begin
            ld_zero1_q <= (ld_pass_q == '0);
            ld_data1_q <= mem_q[{ld_ptr_q, ld_addr_q}];
         end
         if (ld_v1_q) rd_data_q <= ld_zero1_q ? '0 : ld_data1_q;

         dr_v1_q <= dr_issue;
         if (dr_issue) begin
            dr_data1_q <= mem_q[{dr_ptr_q, dr_addr_q}];
            dr_last1_q <= &dr_addr_q;
         end
         if (dr_v1_q) begin
            fifo_data_q[fifo_wp_q] <= dr_data1_q;
            fifo_last_q[fifo_wp_q] <= dr_last1_q;
            fifo_wp_q              <= ~fifo_wp_q;
         end
         if (pop) fifo_rp_q <= ~fifo_rp_q;
         fifo_cnt_q <= fifo_cnt_q + 2'(dr_v1_q) - 2'(pop);
      end
   end

   assign rd_data_out    = rd_data_q;
   assign tile_ready_out = tile_ready_q;
   assign out_valid      = (fifo_cnt_q != 2'd0);
   assign out_data       = fifo_data_q[fifo_rp_q];
   assign out_last       = fifo_last_q[fifo_rp_q];
   assign err_out        = err_q;

endmodule

// File: doc/c_tile_bank_ctrl.md
Name: c_tile_bank_ctrl

Overview:
- Generalised C-tile accumulation buffer for the systolic matrix-multiply array.
- NUM_BANKS-deep ring of partial-sum banks, each holding one C tile, on a single clock.
- Load side reads partial sums (zero on first pass), store side writes them back. After N_in passes a bank retires to a valid/ready drain stream.
- Adds backpressure, error flagging and a last-beat marker.

Parameters:
- D_WIDTH, 64, data width of one C element.
- ADDR_WTH, 2, bank address width; bank depth = 2**ADDR_WTH.
- NUM_BANKS, 2, number of tile banks; power of two, >= 2.
- N_MAX_WIDTH, 32, width of the pass-count input.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- N_in  in  N_MAX_WIDTH  passes per tile. Held static while any bank is not FREE. 0 is treated as 1.
- load_en_in  in  1  read next element of the load bank.
- rd_data_out  out  D_WIDTH  partial sum; 2 cycles after load_en_in.
- store_en_in  in  1  write wr_data_in to the next element of the store bank.
- wr_data_in  in  D_WIDTH  updated partial sum.
- tile_ready_out  out  1  load bank is FREE or ACTIVE; upstream may issue load_en_in.
- out_valid  out  1  drain beat valid.
- out_ready  in  1  drain consumer ready.
- out_data  out  D_WIDTH  drain element.
- out_last  out  1  final element of the drained tile.
- err_out  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - all outputs 0; tile_ready_out becomes 1 one cycle after reset release.
  - all banks FREE.
  - load/store/drain bank pointers, addresses and pass counters 0.
  - rd_data_out pipeline cleared.
- Bank state per bank: FREE, ACTIVE, FULL, DRAINING, as a registered 2-bit code.
- Load side:
  - load_en_in with load bank FREE: bank goes to ACTIVE; the read proceeds.
  - load_en_in with load bank FULL or DRAINING: beat ignored, err_out set.
  - Each accepted load increments load_addr, wrapping at depth.
  - At wrap (load_addr all-ones): load pass count increments. If it equals N_in-1, the count clears and the load pointer advances, mod NUM_BANKS.
- Read path:
  - latency is exactly 2 cycles.
  - rd_data_out is forced to 0 when the load pass count was 0 at issue; the zero flag is pipelined alongside the data.
  - when no read is in flight, rd_data_out holds its last value.
- Store side:
  - store_en_in to a bank not ACTIVE: beat dropped, err_out set.
  - otherwise writes wr_data_in at store_addr; counters wrap as on the load side.
  - on the final wrap of the final pass, the bank goes ACTIVE to FULL and the store pointer advances.
- Drain FSM, states IDLE, RD, HOLD:
  - IDLE: if the bank at the drain pointer is FULL, mark it DRAINING and go to RD.
  - RD: issue a read (2-cycle latency) into a 2-entry skid FIFO; keep issuing while FIFO occupancy plus in-flight reads is below 2.
  - out_valid = FIFO non-empty; a beat transfers when out_valid && out_ready.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - out_last is 1 on the element at address all-ones.
  - after the last beat transfers: bank goes to FREE, drain pointer advances, FSM returns to IDLE.
  - HOLD is entered when the FIFO is full with no pending issue and exited when it has space.
- Drain ordering: tiles drain strictly in completion order.
- Port priority: the store write and the drain read of different banks proceed in the same cycle. A bank never has both the store and drain roles.
- Simultaneous events:
  - a bank freed by drain in cycle t is visible as FREE to load/tile_ready_out at t+1.
  - a load claim and a store final-wrap in the same cycle are both honoured.
- All banks FULL/DRAINING: tile_ready_out is 0; the load side must stall.
- Reset mid-operation: in-flight tile and drain are abandoned; all banks FREE; memory contents are not cleared, since the zero-forcing makes that unnecessary.
- err_out is cleared only by rst.

Test Plan:
- NUM_BANKS=2, depth 4, N_in=2. Pass 0: loads return 0, stores 1,2,3,4. Pass 1: loads return 1,2,3,4, stores 11,12,13,14 -> drain emits 11,12,13,14, out_last on 14, then the bank is FREE.
- Same setup with out_ready toggled 1,0,0,1 per cycle -> out_data/out_last held while stalled, no beat lost or duplicated, 4 beats total.
- 3 tiles back-to-back with out_ready=0 -> tile_ready_out drops to 0 after 2 tiles; raising out_ready drains tile 0 and tile_ready_out rises 1 cycle after its out_last beat.
- store_en_in issued while the store bank is FULL -> write dropped, err_out=1 and sticky, drained data unchanged.
- rst asserted mid-drain (beat 2 of 4) -> outputs 0 asynchronously; a fresh tile afterwards returns zeros on its first pass.
- N_in=0 with NUM_BANKS=4 -> behaves as a 1-pass tile; drain occurs after the first store wrap; banks cycle 0,1,2,3,0.
